// File: rtl/veririsc_datapath.sv
// VeriRISC sequencing/datapath: phase counter, PC, IR and accumulator with a
// single shared memory port. Control strobes arrive combinationally from the
// controller and take effect at the clock edge that ends the current phase.
module veririsc_datapath #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              halt,
    input  logic              ld_pc,
    input  logic              data_e,
    input  logic              ld_ac,
    input  logic              wr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [2:0]        opcode,
    output logic [2:0]        phase,
    output logic              zero,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_oe,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              halted
);

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } op_e;

    logic [2:0]        phase_q, phase_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] ac_q, ac_d;
    logic              halted_q, halted_d;
    op_e               op;

    assign op = op_e'(ir_q[DWIDTH-1 -: 3]);

    // Next-state: everything freezes once halted; a halt request still honours
    // the other strobes sampled at the same edge but stops the phase counter.
    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (ld_ir) begin
                ir_d = mem_rdata;
            end
            if (ld_pc) begin
                pc_d = ir_q[AWIDTH-1:0];
            end else if (inc_pc) begin
                pc_d = pc_q + AWIDTH'(1);
            end
            if (ld_ac) begin
                case (op)
                    OP_ADD:  ac_d = ac_q + mem_rdata;
                    OP_AND:  ac_d = ac_q & mem_rdata;
                    OP_XOR:  ac_d = ac_q ^ mem_rdata;
                    OP_LDA:  ac_d = mem_rdata;
                    default: ac_d = ac_q;
                endcase
            end
            if (halt) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_q + 3'd1;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

    assign opcode    = ir_q[DWIDTH-1 -: 3];
    assign phase     = phase_q;
    assign zero      = (ac_q == '0);
    assign mem_addr  = sel ? pc_q : ir_q[AWIDTH-1:0];
    assign mem_wdata = ac_q;
    assign mem_oe    = data_e;
    assign mem_rd    = rd;
    assign mem_wr    = wr;
    assign halted    = halted_q;

endmodule
